// File: rtl/sort8_chunk_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort8_chunk_scheduler_pkg
// Purpose  : Shared types, widths and FSM encoding for the sort8 chunk scheduler.
// Revision : 1.0
// ============================================================================
package sort8_chunk_scheduler_pkg;

   localparam int unsigned KEY_W = 16;
   localparam int unsigned VAL_W = 16;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } tuple_pair_t;

   localparam int unsigned PAIR_W           = $bits(tuple_pair_t);
   localparam int unsigned ARR_8_FLAT_WIDTH = 8 * PAIR_W;
   localparam int unsigned SORT8_LAT        = 6;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   // Even chunks ascend and odd chunks descend so neighbours form bitonic runs.
   function automatic logic chunk_asc(input logic addr_lsb, input logic alt_dir);
      return alt_dir ? ~addr_lsb : 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sort8_chunk_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sort8_chunk_scheduler_if
// Purpose  : RAM read, sorter and write-back signals between scheduler and its environment.
// Revision : 1.0
// ============================================================================
interface sort8_chunk_scheduler_if #(
   parameter int unsigned ADDR_W = 8
) ();

   localparam int unsigned FW = sort8_chunk_scheduler_pkg::ARR_8_FLAT_WIDTH;

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [FW-1:0]     rd_data;
   logic              srt_valid_in;
   logic              srt_asc;
   logic [FW-1:0]     srt_pairs_in;
   logic              srt_valid_out;
   logic [FW-1:0]     srt_pairs_out;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [FW-1:0]     wr_data;

   modport master (
      output rd_en, rd_addr,
      input  rd_data,
      output srt_valid_in, srt_asc, srt_pairs_in,
      input  srt_valid_out, srt_pairs_out,
      output wr_valid,
      input  wr_ready,
      output wr_addr, wr_data
   );

   modport slave (
      input  rd_en, rd_addr,
      output rd_data,
      input  srt_valid_in, srt_asc, srt_pairs_in,
      output srt_valid_out, srt_pairs_out,
      input  wr_valid,
      output wr_ready,
      input  wr_addr, wr_data
   );

endinterface
`default_nettype wire

// File: rtl/sort8_chunk_scheduler_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Power-of-two synchronous FIFO with registered storage, fall-through head
//            and same-cycle push/pop.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   count_q;
   logic             pop_eff, push_eff;

   assign pop_eff  = pop_i && (count_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_eff = push_i && ((count_q != CNT_FULL) || pop_eff);

   assign head_o  = mem_q[rptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   always_ff @(posedge clock) begin
      if (push_eff) begin
         mem_q[wptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_eff) wptr_q <= wptr_q + PTR_ONE;
         if (pop_eff)  rptr_q <= rptr_q + PTR_ONE;
         case ({push_eff, pop_eff})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(push_i && (count_q == CNT_FULL) && !pop_eff));

endmodule
`default_nettype wire

// File: rtl/sort8_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sort8_chunk_scheduler
// Purpose  : Streams chunks from the pair RAM through the 8-lane sorter and writes the
//            sorted chunks back in place behind a credit-guarded result FIFO.
// Revision : 1.0
// ============================================================================
module sort8_chunk_scheduler
   import sort8_chunk_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter bit          ALT_DIR    = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start_i,
   input  logic [ADDR_W:0]         num_chunks_i,
   output logic                    busy_o,
   output logic                    done_o,
   sort8_chunk_scheduler_if.master bus
);

   localparam int unsigned CRED_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
   localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   num_q, num_d;
   logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
   logic [ADDR_W:0]   wr_idx_q, wr_idx_d;
   logic [CRED_W-1:0] credits_q, credits_d;
   logic              srt_valid_q, srt_asc_q;
   logic              rd_en, pop, fifo_empty;
   logic [CRED_W-1:0] fifo_count;

   assign rd_en = (state_q == ST_ISSUE) && (credits_q != '0);
   assign pop   = !fifo_empty && bus.wr_ready;

   assign bus.rd_en        = rd_en;
   assign bus.rd_addr      = rd_idx_q[ADDR_W-1:0];
   assign bus.srt_valid_in = srt_valid_q;
   assign bus.srt_asc      = srt_asc_q;
   assign bus.srt_pairs_in = bus.rd_data;
   assign bus.wr_valid     = !fifo_empty;
   assign bus.wr_addr      = wr_idx_q[ADDR_W-1:0];

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_FINISH);

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      rd_idx_d  = rd_en ? rd_idx_q + IDX_ONE : rd_idx_q;
      wr_idx_d  = pop   ? wr_idx_q + IDX_ONE : wr_idx_q;
      credits_d = credits_q;
      // A credit covers one chunk from its RAM read until its write-back leaves the FIFO.
      if (rd_en && !pop) begin
         credits_d = credits_q - CRED_ONE;
      end else if (!rd_en && pop) begin
         credits_d = credits_q + CRED_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               num_d    = num_chunks_i;
               rd_idx_d = '0;
               wr_idx_d = '0;
               state_d  = (num_chunks_i == '0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rd_en && (rd_idx_d == num_q)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (wr_idx_d == num_q) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         num_q       <= '0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         credits_q   <= CRED_INIT;
         srt_valid_q <= 1'b0;
         srt_asc_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         credits_q   <= credits_d;
         srt_valid_q <= rd_en;
         srt_asc_q   <= chunk_asc(rd_idx_q[0], ALT_DIR);
      end
   end

   sync_fifo #(
      .WIDTH (ARR_8_FLAT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (bus.srt_valid_out),
      .push_data_i (bus.srt_pairs_out),
      .pop_i       (pop),
      .head_o      (bus.wr_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   a_credit_cap: assert property (@(posedge clock) disable iff (!reset_n)
      credits_q <= CRED_INIT);

   a_fifo_within_credit: assert property (@(posedge clock) disable iff (!reset_n)
      ({1'b0, fifo_count} + {1'b0, credits_q}) <= (CRED_W+1)'(FIFO_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_sort8_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort8_chunk_scheduler
// Purpose  : Self-checking bench with RAM and sorter models around the chunk scheduler.
// Revision : 1.0
// ============================================================================
module tb_sort8_chunk_scheduler;
   import sort8_chunk_scheduler_pkg::*;

   localparam int AW  = 8;
   localparam int FW  = ARR_8_FLAT_WIDTH;
   localparam int PW  = PAIR_W;
   localparam bit ALT = 1'b1;

   typedef struct {
      int num;
      int mode;
      int exp_writes;
      int exp_dones;
   } vec_t;

   typedef struct {
      int            addr;
      logic [FW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_chunks = '0;
   logic          busy, done;
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            ready_mode = 0;
   logic [FW-1:0] ram [256];

   wr_t wq [$];
   int  rdc_q [$];
   int  done_q [$];
   bit  asc_q [$];
   int  wv_cnt = 0;
   wr_t w_mon;

   int wbase, rbase, dbase, abase, vbase, start_cyc;

   sort8_chunk_scheduler_if #(.ADDR_W(AW)) bus ();

   sort8_chunk_scheduler #(
      .ADDR_W     (AW),
      .FIFO_DEPTH (8),
      .ALT_DIR    (ALT)
   ) dut (
      .clock        (clk),
      .reset_n      (reset_n),
      .start_i      (start),
      .num_chunks_i (num_chunks),
      .busy_o       (busy),
      .done_o       (done),
      .bus          (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference sorter: plain bubble sort on the key field.
   function automatic logic [FW-1:0] ref_sort(input logic [FW-1:0] d, input bit asc);
      tuple_pair_t   a [8];
      tuple_pair_t   t;
      logic [FW-1:0] r;
      for (int i = 0; i < 8; i++) a[i] = d[i*PW +: PW];
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 7 - i; j++) begin
            if (asc ? (a[j].key > a[j+1].key) : (a[j].key < a[j+1].key)) begin
               t      = a[j];
               a[j]   = a[j+1];
               a[j+1] = t;
            end
         end
      end
      for (int i = 0; i < 8; i++) r[i*PW +: PW] = a[i];
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
   end

   logic [FW-1:0] sd [SORT8_LAT];
   logic          sv [SORT8_LAT];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SORT8_LAT; i++) sv[i] <= 1'b0;
      end else begin
         sv[0] <= bus.srt_valid_in;
         sd[0] <= ref_sort(bus.srt_pairs_in, bus.srt_asc);
         for (int i = 1; i < SORT8_LAT; i++) begin
            sv[i] <= sv[i-1];
            sd[i] <= sd[i-1];
         end
      end
   end
   assign bus.srt_valid_out = sv[SORT8_LAT-1];
   assign bus.srt_pairs_out = sd[SORT8_LAT-1];

   initial begin
      bus.wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.wr_ready = 1'b0;
            1:       bus.wr_ready = 1'b1;
            default: bus.wr_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   always @(negedge clk) begin
      if (bus.wr_valid && bus.wr_ready) begin
         w_mon.addr = int'(bus.wr_addr);
         w_mon.data = bus.wr_data;
         wq.push_back(w_mon);
      end
      if (bus.rd_en)        rdc_q.push_back(cyc);
      if (done)             done_q.push_back(cyc);
      if (bus.srt_valid_in) asc_q.push_back(bus.srt_asc);
      if (bus.wr_valid)     wv_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected test end");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_ram(input int num);
      for (int k = 0; k < num; k++) begin
         for (int l = 0; l < 8; l++) ram[k][l*PW +: PW] = $urandom;
      end
   endtask

   task automatic begin_pass(input int num);
      wbase = wq.size();
      rbase = rdc_q.size();
      dbase = done_q.size();
      abase = asc_q.size();
      vbase = wv_cnt;
      @(posedge clk);
      #1;
      start      = 1'b1;
      num_chunks = (AW+1)'(num);
      start_cyc  = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic finish_pass(input int budget);
      int n;
      n = 0;
      while (done_q.size() == dbase && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("done_count", done_q.size() - dbase, 1);
      chk("busy_after_done", busy, 1'b0);
   endtask

   task automatic check_writes(input int num);
      chk("wr_count", wq.size() - wbase, num);
      chk("rd_count", rdc_q.size() - rbase, num);
      for (int k = 0; k < num && wbase + k < wq.size(); k++) begin
         chk("wr_addr", wq[wbase+k].addr, k);
         chk("wr_data", wq[wbase+k].data, ref_sort(ram[k], ALT ? (k % 2 == 0) : 1'b1));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},         busy,             1'b0);
      chk({tag, "_done"},         done,             1'b0);
      chk({tag, "_rd_en"},        bus.rd_en,        1'b0);
      chk({tag, "_rd_addr"},      bus.rd_addr,      '0);
      chk({tag, "_srt_valid_in"}, bus.srt_valid_in, 1'b0);
      chk({tag, "_srt_asc"},      bus.srt_asc,      1'b1);
      chk({tag, "_wr_valid"},     bus.wr_valid,     1'b0);
      chk({tag, "_wr_addr"},      bus.wr_addr,      '0);
   endtask

   initial begin
      vec_t          vecs [5];
      tuple_pair_t   p;
      logic [FW-1:0] c1;

      vecs[0] = '{num: 1,  mode: 1, exp_writes: 1,  exp_dones: 1};
      vecs[1] = '{num: 3,  mode: 2, exp_writes: 3,  exp_dones: 1};
      vecs[2] = '{num: 7,  mode: 2, exp_writes: 7,  exp_dones: 1};
      vecs[3] = '{num: 0,  mode: 2, exp_writes: 0,  exp_dones: 1};
      vecs[4] = '{num: 16, mode: 2, exp_writes: 16, exp_dones: 1};

      reset_n    = 1'b0;
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      reset_n = 1'b1;

      // Four chunks at full throughput; chunk 1 holds keys 0..7 in order.
      ready_mode = 1;
      fill_ram(4);
      for (int l = 0; l < 8; l++) begin
         p.key = KEY_W'(l);
         p.val = VAL_W'($urandom);
         ram[1][l*PW +: PW] = p;
      end
      begin_pass(4);
      finish_pass(100);
      check_writes(4);
      if (rdc_q.size() - rbase == 4) chk("rd_back_to_back", rdc_q[rbase+3] - rdc_q[rbase], 3);
      for (int i = 0; i < 4 && abase + i < asc_q.size(); i++)
         chk("srt_asc_seq", asc_q[abase+i], (i % 2 == 0));
      if (wq.size() > wbase + 1) begin
         c1 = wq[wbase+1].data;
         for (int i = 0; i < 8; i++) begin
            p = c1[i*PW +: PW];
            chk("chunk1_desc_key", p.key, 7 - i);
         end
      end
      // Latency counted from the first read strobe: 4 issues + 7 pipeline + 1 write-back.
      if (done_q.size() > dbase && rdc_q.size() > rbase)
         chk("done_latency", done_q[dbase] - rdc_q[rbase], 4 + 7 + 1);

      // Empty pass goes straight to FINISH.
      begin_pass(0);
      finish_pass(20);
      if (done_q.size() > dbase) chk("zero_done_delay", done_q[dbase] - start_cyc, 1);
      chk("zero_rd_en", rdc_q.size() - rbase, 0);
      chk("zero_wr_valid", wv_cnt - vbase, 0);

      for (int v = 0; v < 5; v++) begin
         ready_mode = vecs[v].mode;
         fill_ram(vecs[v].num);
         begin_pass(vecs[v].num);
         finish_pass(400);
         chk("vec_writes", wq.size() - wbase, vecs[v].exp_writes);
         chk("vec_dones", done_q.size() - dbase, vecs[v].exp_dones);
         check_writes(vecs[v].num);
      end

      // Write-back stalled: issue must stop once all credits are used.
      ready_mode = 0;
      fill_ram(20);
      begin_pass(20);
      repeat (30) @(posedge clk);
      #1;
      chk("stall_reads", rdc_q.size() - rbase, 8);
      chk("stall_rd_en", bus.rd_en, 1'b0);
      ready_mode = 1;
      finish_pass(200);
      check_writes(20);

      // Full address range with random back-pressure.
      ready_mode = 2;
      fill_ram(256);
      begin_pass(256);
      finish_pass(4000);
      check_writes(256);

      // Reset in DRAIN aborts the pass silently.
      ready_mode = 0;
      fill_ram(8);
      begin_pass(8);
      repeat (15) @(posedge clk);
      #1;
      chk("pre_reset_busy", busy, 1'b1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk_reset("midrst");
      ready_mode = 1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", done_q.size() - dbase, 0);
      chk("abort_no_write", wq.size() - wbase, 0);
      fill_ram(2);
      begin_pass(2);
      finish_pass(50);
      check_writes(2);

      // Start during ISSUE is ignored.
      ready_mode = 1;
      fill_ram(12);
      begin_pass(12);
      @(posedge clk);
      #1;
      start      = 1'b1;
      num_chunks = (AW+1)'(9);
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_pass(100);
      check_writes(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
